// File: rtl/qsub_pipe.sv
// Two-stage sign-magnitude subtractor c = a - b with valid/ready on both sides.
// Define QSUB_SAT_EN to saturate the magnitude on add-path overflow instead of wrapping.
module qsub_pipe #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);
  localparam int M = N - 1;

  if (Q >= M) begin : g_bad_q
    $error("qsub_pipe: Q must be smaller than the magnitude width");
  end

  // Stage 1 state
  logic         s1_valid_q, s1_add_q, s1_sign_q, s1_eq_q;
  logic [M-1:0] s1_big_q, s1_small_q;
  logic         s1_add_d, s1_sign_d, s1_eq_d;
  logic [M-1:0] s1_big_d, s1_small_d;

  // Stage 2 state
  logic         s2_valid_q, ovf_q, ovf_d;
  logic [N-1:0] c_q, c_d;

  logic         s2_adv, s1_load;
  logic [M-1:0] mag_a, mag_b;
  logic         sa, sb, a_ge;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid_q;
  assign c         = c_q;
  assign ovf       = ovf_q;

  // Effective signs; a zero magnitude always counts as +0.
  assign mag_a = a[M-1:0];
  assign mag_b = b[M-1:0];
  assign sa    = a[N-1] & (|mag_a);
  assign sb    = ~b[N-1] & (|mag_b);
  assign a_ge  = mag_a >= mag_b;

  always_comb begin
    s1_add_d   = (sa == sb);
    s1_big_d   = a_ge ? mag_a : mag_b;
    s1_small_d = a_ge ? mag_b : mag_a;
    s1_eq_d    = (mag_a == mag_b);
    s1_sign_d  = s1_add_d ? sa : (a_ge ? sa : sb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_add_q   <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_big_q   <= '0;
      s1_small_q <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (s1_load) begin
        s1_add_q   <= s1_add_d;
        s1_sign_q  <= s1_sign_d;
        s1_eq_q    <= s1_eq_d;
        s1_big_q   <= s1_big_d;
        s1_small_q <= s1_small_d;
      end
    end
  end

  logic [N-1:0] sum;
  logic [M-1:0] diff, mag;
  logic         sgn;

  always_comb begin
    sum  = {1'b0, s1_big_q} + {1'b0, s1_small_q};
    diff = s1_big_q - s1_small_q;
    sgn  = s1_sign_q;
    ovf_d = 1'b0;
    if (s1_add_q) begin
      mag   = sum[M-1:0];
      ovf_d = sum[N-1];
`ifdef QSUB_SAT_EN
      if (sum[N-1]) mag = '1;
`endif
    end else begin
      mag = s1_eq_q ? '0 : diff;
    end
    // Never emit negative zero, including a wrapped overflow.
    if (mag == '0) sgn = 1'b0;
    c_d = {sgn, mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      ovf_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        c_q   <= c_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_qsub_pipe.sv
// Directed-vector bench for qsub_pipe: arithmetic, zero/overflow cases, backpressure, async reset.
module tb_qsub_pipe;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0, b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  c;
  logic          ovf;

  int nvec = 0;
  int nerr = 0;

  qsub_pipe #(.N(N), .Q(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single operand with out_ready high: result is visible after the second edge.
  task automatic one(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                     input logic [N-1:0] ec, input logic eo);
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1;
    chk({tag, "_rdy"}, N'(in_ready), N'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, N'(out_valid), N'(0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, N'(out_valid), N'(1));
    chk({tag, "_c"}, c, ec);
    chk({tag, "_ovf"}, N'(ovf), N'(eo));
  endtask

  localparam logic [N-1:0] RA = 32'h0000_4000;
  localparam logic [N-1:0] RB = 32'h8000_4000;
  localparam logic [N-1:0] RC = 32'h8001_0000;

  initial begin
    logic [N-1:0] ovf_c;
`ifdef QSUB_SAT_EN
    ovf_c = 32'h7FFF_FFFF;
`else
    ovf_c = 32'h0000_0000;
`endif
    #12;
    chk("rst_vld", N'(out_valid), N'(0));
    chk("rst_c", c, '0);
    chk("rst_ovf", N'(ovf), N'(0));
    chk("rst_rdy", N'(in_ready), N'(1));
    @(negedge clk);
    rst_n = 1'b1;

    one("sub_pos", 32'h0000_8000, 32'h0000_4000, RA, 1'b0);
    one("sub_neg", 32'h0000_4000, 32'h0000_8000, RB, 1'b0);
    one("add_neg", 32'h8000_8000, 32'h0000_8000, RC, 1'b0);
    one("eq_zero", 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0);
    one("neg_zero", 32'h8000_0000, 32'h0000_0000, 32'h0, 1'b0);
    one("ovf", 32'h7FFF_FFFF, 32'h8000_0001, ovf_c, 1'b1);
    one("mixed", 32'h8000_1000, 32'h8000_3000, 32'h0000_2000, 1'b0);

    // Backpressure: three back-to-back offers, only two fit.
    @(negedge clk);
    out_ready = 1'b0;
    a = 32'h0000_8000; b = 32'h0000_4000; in_valid = 1'b1;
    chk("bp_rdy0", N'(in_ready), N'(1));
    @(posedge clk);
    @(negedge clk);
    a = 32'h0000_4000; b = 32'h0000_8000;
    chk("bp_rdy1", N'(in_ready), N'(1));
    @(posedge clk);
    @(negedge clk);
    a = 32'h8000_8000; b = 32'h0000_8000;
    chk("bp_rdy2", N'(in_ready), N'(0));
    chk("bp_vld", N'(out_valid), N'(1));
    chk("bp_c0", c, RA);
    @(posedge clk);
    @(negedge clk);
    chk("bp_hold_c", c, RA);
    chk("bp_hold_rdy", N'(in_ready), N'(0));
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", N'(in_ready), N'(1));
    chk("bp_out0", c, RA);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out1_vld", N'(out_valid), N'(1));
    chk("bp_out1", c, RB);
    @(posedge clk);
    @(negedge clk);
    chk("bp_out2_vld", N'(out_valid), N'(1));
    chk("bp_out2", c, RC);
    @(posedge clk);
    @(negedge clk);
    chk("bp_drain", N'(out_valid), N'(0));

    // Fill both stages, then reset asynchronously between edges.
    out_ready = 1'b0;
    a = 32'h8000_8000; b = 32'h0000_8000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'h0000_8000; b = 32'h0000_4000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_rdy", N'(in_ready), N'(0));
    chk("full_c", c, RC);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_vld", N'(out_valid), N'(0));
    chk("arst_c", c, '0);
    chk("arst_ovf", N'(ovf), N'(0));
    chk("arst_rdy", N'(in_ready), N'(1));
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_idle", N'(out_valid), N'(0));
    end
    one("post_rst", 32'h0000_4000, 32'h8000_4000, 32'h0000_8000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
